// File: rtl/tengigeth_loop_frame_gen_pkg.sv
// Shared types and constants for the 10GbE loopback frame generator
// and its companion checker.
package tengigeth_loop_frame_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int AXIS_BYTES      = 8;
  localparam int DEF_MIN_PAYLOAD = 46;
  localparam int DEF_MAX_PAYLOAD = 1500;

  // Byte enables of a frame's final beat from frame length mod 8
  function automatic logic [7:0] tkeep_from_rem(
    input logic [2:0] rem
  );
    logic [7:0] k;
    unique case (rem)
      3'd0: k = 8'hFF;
      3'd1: k = 8'h01;
      3'd2: k = 8'h03;
      3'd3: k = 8'h07;
      3'd4: k = 8'h0F;
      3'd5: k = 8'h1F;
      3'd6: k = 8'h3F;
      3'd7: k = 8'h7F;
      default: k = 8'hFF;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/tengigeth_loop_frame_gen_payload_pattern.sv
// Deterministic payload bytes for one 64-bit beat:
// lane k carries (seq + offset + k) mod 256.
module tengigeth_loop_payload_pattern
  import tengigeth_loop_frame_gen_pkg::*;
(
  input  logic [7:0]  seq,
  input  logic [7:0]  offset,
  output logic [63:0] data
);

  logic [7:0] base;

  assign base = seq + offset;

  always_comb begin
    data = '0;
    for (int k = 0; k < AXIS_BYTES; k++) begin
      data[8*k +: 8] = base + 8'(k);
    end
  end

endmodule

// File: rtl/tengigeth_loop_frame_gen.sv
// Ethernet II test-frame generator driving a registered 64-bit
// AXI4-Stream toward the MAC TX / loopback swapper.
module tengigeth_loop_frame_gen
  import tengigeth_loop_frame_gen_pkg::*;
#(
  parameter int GAP_BEATS   = 2,
  parameter int MIN_PAYLOAD = DEF_MIN_PAYLOAD,
  parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD
) (
  input  logic        piEthCoreClk,
  input  logic        piReset_n,
  input  logic        piGenEn,
  input  logic [47:0] piDstMac,
  input  logic [47:0] piSrcMac,
  input  logic [15:0] piEtherType,
  input  logic [13:0] piPayloadLen,
  input  logic [15:0] piFrameCnt,
  input  logic        pi_Axis_tready,
  output logic [63:0] po_Axis_tdata,
  output logic [7:0]  po_Axis_tkeep,
  output logic        po_Axis_tlast,
  output logic        po_Axis_tvalid,
  output logic        poBusy,
  output logic        poDone,
  output logic [31:0] poFramesSent
);

  localparam logic [13:0] MIN_P    = 14'(MIN_PAYLOAD);
  localparam logic [13:0] MAX_P    = 14'(MAX_PAYLOAD);
  localparam logic [13:0] HDR_L    = 14'(ETH_HDR_BYTES);
  localparam logic [15:0] GAP_LAST = 16'(GAP_BEATS - 1);
  localparam bit          HAS_GAP  = (GAP_BEATS > 0);

  state_e      state_q, state_d;
  logic [13:0] beat_q, beat_d;
  logic [13:0] nbeats_q, nbeats_d;
  logic [7:0]  klast_q, klast_d;
  logic [7:0]  seq_q, seq_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [15:0] et_q, et_d;
  logic [15:0] run_q, run_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] sent_q, sent_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tvalid_q, tvalid_d;

  logic        xfer;
  logic        start;
  logic        leave;
  logic        load;
  logic [13:0] plen;
  logic [13:0] flen;
  logic [13:0] nbeats_in;
  logic [7:0]  pat_off;
  logic [63:0] pat;
  logic        last_b;
  logic [7:0]  keep_b;
  logic [63:0] beat_b;

  assign xfer = tvalid_q & pi_Axis_tready;

  always_comb begin
    plen = piPayloadLen;
    if (piPayloadLen < MIN_P) begin
      plen = MIN_P;
    end else if (piPayloadLen > MAX_P) begin
      plen = MAX_P;
    end
  end

  assign flen      = HDR_L + plen;
  assign nbeats_in = (flen + 14'd7) >> 3;

  always_ff @(posedge piEthCoreClk or negedge piReset_n) begin
    if (!piReset_n) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      nbeats_q <= '0;
      klast_q  <= '0;
      seq_q    <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      et_q     <= '0;
      run_q    <= '0;
      gap_q    <= '0;
      sent_q   <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      nbeats_q <= nbeats_d;
      klast_q  <= klast_d;
      seq_q    <= seq_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      et_q     <= et_d;
      run_q    <= run_d;
      gap_q    <= gap_d;
      sent_q   <= sent_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    nbeats_d = nbeats_q;
    klast_d  = klast_q;
    seq_d    = seq_q;
    dst_d    = dst_q;
    src_d    = src_q;
    et_d     = et_q;
    run_d    = run_q;
    gap_d    = gap_q;
    sent_d   = sent_q;
    start    = 1'b0;
    leave    = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        start = piGenEn;
      end
      ST_HDR0: begin
        if (xfer) begin
          state_d = ST_HDR1;
          beat_d  = 14'd1;
          load    = 1'b1;
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          state_d = ST_PAYLOAD;
          beat_d  = 14'd2;
          load    = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          if (tlast_q) begin
            sent_d = sent_q + 32'd1;
            run_d  = run_q + 16'd1;
            if (HAS_GAP) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else begin
              leave = 1'b1;
            end
          end else begin
            beat_d = beat_q + 14'd1;
            load   = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          leave = 1'b1;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_DONE: begin
        if (!piGenEn) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (leave) begin
      if (!piGenEn) begin
        state_d = ST_IDLE;
      end else if (piFrameCnt != 16'd0 &&
                   run_d == piFrameCnt) begin
        state_d = ST_DONE;
      end else begin
        start = 1'b1;
      end
    end
    if (state_d == ST_IDLE) begin
      run_d = '0;
    end
    // Frame index within the run seeds the payload pattern
    if (start) begin
      state_d  = ST_HDR0;
      beat_d   = '0;
      nbeats_d = nbeats_in;
      klast_d  = tkeep_from_rem(flen[2:0]);
      seq_d    = run_d[7:0];
      dst_d    = piDstMac;
      src_d    = piSrcMac;
      et_d     = piEtherType;
      load     = 1'b1;
    end
  end

  // Lane 0 payload index is 8*beat-14; mod 256 also covers beat 1
  assign pat_off = {beat_d[4:0], 3'b000} - 8'd14;

  tengigeth_loop_payload_pattern u_pattern (
    .seq    (seq_d),
    .offset (pat_off),
    .data   (pat)
  );

  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    last_b   = (beat_d == nbeats_d - 14'd1);
    keep_b   = last_b ? klast_d : 8'hFF;
    beat_b   = pat;
    unique case (1'b1)
      (beat_d == 14'd0): begin
        beat_b = {src_d[39:32], src_d[47:40],
                  dst_d[7:0],   dst_d[15:8],
                  dst_d[23:16], dst_d[31:24],
                  dst_d[39:32], dst_d[47:40]};
      end
      (beat_d == 14'd1): begin
        beat_b = {pat[63:48],
                  et_d[7:0],    et_d[15:8],
                  src_d[7:0],   src_d[15:8],
                  src_d[23:16], src_d[31:24]};
      end
      default: begin
      end
    endcase
    for (int k = 0; k < AXIS_BYTES; k++) begin
      if (!keep_b[k]) begin
        beat_b[8*k +: 8] = 8'h00;
      end
    end
    if (load) begin
      tdata_d  = beat_b;
      tkeep_d  = keep_b;
      tlast_d  = last_b;
      tvalid_d = 1'b1;
    end else if (xfer) begin
      tdata_d  = '0;
      tkeep_d  = '0;
      tlast_d  = 1'b0;
      tvalid_d = 1'b0;
    end
  end

  assign po_Axis_tdata  = tdata_q;
  assign po_Axis_tkeep  = tkeep_q;
  assign po_Axis_tlast  = tlast_q;
  assign po_Axis_tvalid = tvalid_q;
  assign poBusy         = (state_q != ST_IDLE);
  assign poDone         = (state_q == ST_DONE);
  assign poFramesSent   = sent_q;

endmodule

// File: tb/tb_tengigeth_loop_frame_gen.sv
// Scoreboard bench for the loopback frame generator: a byte-level
// frame model feeds expected beats, a negedge monitor consumes them.
module tb_tengigeth_loop_frame_gen;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [47:0] da = 48'h000A35010203;
  logic [47:0] sa = 48'h000A350A0B0C;
  logic [15:0] et = 16'h88B5;
  logic [13:0] plen = 14'd46;
  logic [15:0] fcnt = 16'd1;
  logic        tready = 1'b1;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        busy;
  logic        done;
  logic [31:0] sent;

  beat_t sbq[$];
  int    checks = 0;
  int    fails = 0;
  bit    bp_en = 1'b0;
  bit    gap_chk = 1'b0;
  int    fbeats = 0;
  int    last_nb = 0;
  int    gapcnt = 0;
  bit    gap_arm = 1'b0;
  bit    stall = 1'b0;
  logic [63:0] first_d = '0;
  logic [63:0] stall_d = '0;
  logic [7:0]  stall_k = '0;
  logic        stall_l = 1'b0;
  logic [7:0]  last_k = '0;

  always #5 clk = ~clk;

  tengigeth_loop_frame_gen #(
    .GAP_BEATS   (2),
    .MIN_PAYLOAD (46),
    .MAX_PAYLOAD (1500)
  ) dut (
    .piEthCoreClk   (clk),
    .piReset_n      (rst_n),
    .piGenEn        (en),
    .piDstMac       (da),
    .piSrcMac       (sa),
    .piEtherType    (et),
    .piPayloadLen   (plen),
    .piFrameCnt     (fcnt),
    .pi_Axis_tready (tready),
    .po_Axis_tdata  (tdata),
    .po_Axis_tkeep  (tkeep),
    .po_Axis_tlast  (tlast),
    .po_Axis_tvalid (tvalid),
    .poBusy         (busy),
    .poDone         (done),
    .poFramesSent   (sent)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [47:0] a,
                            input logic [47:0] s,
                            input logic [15:0] t,
                            input int praw,
                            input int seq);
    logic [7:0] fb [1536];
    int p;
    int len;
    int nb;
    beat_t e;
    p = (praw < 46) ? 46 : ((praw > 1500) ? 1500 : praw);
    len = 14 + p;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = a[47-8*i -: 8];
      fb[6 + i] = s[47-8*i -: 8];
    end
    fb[12] = t[15:8];
    fb[13] = t[7:0];
    for (int j = 0; j < p; j++) fb[14 + j] = 8'(seq + j);
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int ln = 0; ln < 8; ln++) begin
        if (8*b + ln < len) begin
          e.d[8*ln +: 8] = fb[8*b + ln];
          e.k[ln] = 1'b1;
        end
      end
      e.l = (b == nb - 1);
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stall   = 1'b0;
      fbeats  = 0;
      gap_arm = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 64'(tvalid), 64'd1);
        chk("hold_data", tdata, stall_d);
        chk("hold_keep", 64'(tkeep), 64'(stall_k));
        chk("hold_last", 64'(tlast), 64'(stall_l));
      end
      tready = bp_en ? ($urandom_range(3, 0) != 0) : 1'b1;
      if (!gap_chk) begin
        gap_arm = 1'b0;
      end else if (gap_arm) begin
        if (!tvalid) begin
          gapcnt++;
        end else begin
          chk("gap_len", 64'(gapcnt), 64'd2);
          gap_arm = 1'b0;
        end
      end
      if (tvalid && tready) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 64'(tvalid), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("tdata", tdata, e.d);
          chk("tkeep", 64'(tkeep), 64'(e.k));
          chk("tlast", 64'(tlast), 64'(e.l));
        end
        if (fbeats == 0) first_d = tdata;
        fbeats++;
        if (tlast) begin
          last_nb = fbeats;
          last_k  = tkeep;
          fbeats  = 0;
          gap_arm = gap_chk;
          gapcnt  = 0;
        end
      end
      stall   = tvalid && !tready;
      stall_d = tdata;
      stall_k = tkeep;
      stall_l = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int praw, input int cnt,
                           input int n);
    plen = 14'(praw);
    fcnt = 16'(cnt);
    for (int i = 0; i < n; i++) push_frame(da, sa, et, praw, i % 256);
    en = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(sbq.size()), 64'd0);
  endtask

  task automatic wait_beats(input string tag, input int nb,
                            input int budget);
    int n = 0;
    while (fbeats != nb && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(fbeats), 64'(nb));
  endtask

  task automatic stop_run();
    en = 1'b0;
    repeat (4) tick();
    chk("busy_off", 64'(busy), 64'd0);
    chk("done_off", 64'(done), 64'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(tvalid), 64'd0);
    chk("rst_last", 64'(tlast), 64'd0);
    chk("rst_data", tdata, 64'd0);
    chk("rst_keep", 64'(tkeep), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sent", 64'(sent), 64'd0);
    rst_n = 1'b1;
    tick();

    start_run(46, 1, 1);
    chk("lat_pre", 64'(tvalid), 64'd0);
    tick();
    chk("lat_first", 64'(tvalid), 64'd1);
    wait_done("done_p46", 200);
    chk("sent_p46", 64'(sent), 64'd1);
    chk("beat0_p46", first_d, 64'h0A00030201350A00);
    chk("nb_p46", 64'(last_nb), 64'd8);
    chk("keep_p46", 64'(last_k), 64'h0F);
    stop_run();

    start_run(50, 1, 1);
    wait_done("done_p50", 200);
    chk("sent_p50", 64'(sent), 64'd2);
    chk("nb_p50", 64'(last_nb), 64'd8);
    chk("keep_p50", 64'(last_k), 64'hFF);
    stop_run();

    start_run(10, 1, 1);
    wait_done("done_p10", 200);
    chk("sent_p10", 64'(sent), 64'd3);
    chk("nb_p10", 64'(last_nb), 64'd8);
    chk("keep_p10", 64'(last_k), 64'h0F);
    stop_run();

    start_run(1600, 1, 1);
    tick();
    tick();
    plen = 14'd46;
    da = 48'h0;
    wait_done("done_p1600", 400);
    chk("sent_p1600", 64'(sent), 64'd4);
    chk("nb_p1600", 64'(last_nb), 64'd190);
    chk("keep_p1600", 64'(last_k), 64'h03);
    stop_run();
    da = 48'h000A35010203;

    gap_chk = 1'b1;
    start_run(46, 0, 4);
    wait_empty("drain_gap", 200);
    gap_chk = 1'b0;
    stop_run();
    chk("sent_gap", 64'(sent), 64'd8);

    start_run(1500, 0, 1);
    wait_beats("beat3_wait", 3, 50);
    en = 1'b0;
    wait_empty("drain_stop", 500);
    stop_run();
    chk("sent_stop", 64'(sent), 64'd9);

    start_run(46, 0, 1);
    wait_beats("beat7_wait", 7, 50);
    chk("pre_rst_last", 64'(tlast), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(tvalid), 64'd0);
    chk("mid_rst_last", 64'(tlast), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_sent", 64'(sent), 64'd0);
    sbq.delete();
    repeat (2) tick();
    fcnt = 16'd1;
    push_frame(da, sa, et, 46, 0);
    rst_n = 1'b1;
    wait_done("done_rst", 200);
    chk("sent_rst", 64'(sent), 64'd1);
    chk("beat0_rst", first_d, 64'h0A00030201350A00);
    stop_run();

    bp_en = 1'b1;
    start_run(60, 100, 100);
    wait_done("done_bp", 20000);
    bp_en = 1'b0;
    chk("sent_bp", 64'(sent), 64'd101);
    chk("drain_bp", 64'(sbq.size()), 64'd0);
    stop_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/tengigeth_loop_frame_gen.md
Name: tengigeth_loop_frame_gen

Overview:
- Test-frame transmitter for the 10GbE loopback path, on the send side of the MAC address swapper.
- Builds Ethernet II frames (DA, SA, EtherType, deterministic payload) and drives them as a 64-bit AXI4-Stream toward the MAC TX or loopback.
- Frames returned through the swapper come back with DA/SA exchanged, so a checker can match them against the programmed values.

Parameters:
- GAP_BEATS, 2, idle cycles with tvalid low between consecutive frames (0 allowed).
- MIN_PAYLOAD, 46, lower clamp on payload bytes.
- MAX_PAYLOAD, 1500, upper clamp on payload bytes.

Ports:
- piEthCoreClk  in  1  core clock, 156.25 MHz.
- piReset_n  in  1  asynchronous active-low reset.
- piGenEn  in  1  generation enable, level.
- piDstMac  in  48  destination MAC; [47:40] is the first byte on the wire.
- piSrcMac  in  48  source MAC, same byte order.
- piEtherType  in  16  EtherType; [15:8] is sent first.
- piPayloadLen  in  14  payload bytes, clamped.
- piFrameCnt  in  16  frames per run; 0 = continuous.
- pi_Axis_tready  in  1  downstream ready.
- po_Axis_tdata  out  64  byte k on [8k+7:8k].
- po_Axis_tkeep  out  8  byte enables.
- po_Axis_tlast  out  1  last beat of frame.
- po_Axis_tvalid  out  1  beat valid.
- poBusy  out  1  high while not in IDLE.
- poDone  out  1  high in DONE state.
- poFramesSent  out  32  frames completed since reset; wraps.

Behaviour:
- Reset: asynchronous on piReset_n low. All outputs are 0, FSM is IDLE, counters are 0. Reset mid-frame aborts the frame immediately with no tlast.
- All AXIS outputs are registered.
- Handshake: a beat transfers when tvalid & tready. While tvalid is high and tready is low, tdata, tkeep and tlast hold stable. tvalid never drops without a transfer.
- FSM states: IDLE, HDR0, HDR1, PAYLOAD, GAP, DONE.
  - IDLE: when piGenEn=1, latch the clamped payload length P, piDstMac, piSrcMac and piEtherType, then go to HDR0. The first tvalid appears one cycle after piGenEn is sampled high.
  - HDR0: bytes 0-5 = DA, bytes 6-7 = SA[47:32].
  - HDR1: bytes 8-11 = SA[31:0], bytes 12-13 = EtherType, bytes 14-15 = payload bytes 0 and 1.
  - PAYLOAD: payload byte i = (seq + i) mod 256, where seq = low 8 bits of the frame index within the run.
  - On the tlast transfer, poFramesSent is incremented. Next state is GAP if GAP_BEATS>0, otherwise HDR0 directly (back-to-back).
  - GAP: hold for GAP_BEATS cycles, then leave.
  - Leaving GAP or the tlast beat: if piGenEn=0, go to IDLE. If piFrameCnt≠0 and the run count equals piFrameCnt, go to DONE. Otherwise go to HDR0 with fresh latched inputs.
  - DONE: stay until piGenEn=0, then go to IDLE.
- piGenEn deasserted mid-frame: the current frame always completes.
- Length arithmetic:
  - L = 14 + P.
  - Beat count = ceil(L/8).
  - Last-beat tkeep = 0xFF if L mod 8 = 0, else (1<<(L mod 8))−1.
  - Bytes of the last beat beyond the frame end are driven 0.
  - Non-last beats carry tkeep 0xFF.
- Clamp: P<MIN_PAYLOAD is treated as MIN_PAYLOAD; P>MAX_PAYLOAD is treated as MAX_PAYLOAD.
- Input changes mid-frame have no effect until the next frame start.
- The run counter clears on entry to IDLE.
- poFramesSent wraps from 0xFFFFFFFF to 0.

Decomposition:
- Shared package holds:
  - FSM state encodings.
  - ETH_HDR_BYTES=14.
  - AXIS_BYTES=8.
  - Default MIN/MAX payload.
  - The tkeep-from-remainder function, which the companion loopback checker also uses.
- One natural sub-module, tengigeth_loop_payload_pattern: it produces the 8 payload bytes for a given beat from seq and the byte offset. The top-level FSM only muxes header versus pattern.

Test Plan:
- DA=00:0A:35:01:02:03, SA=00:0A:35:0A:0B:0C, P=46, piFrameCnt=1, tready=1 → 8 beats; beat0 tdata=0x0A00030201350A00; beat7 tkeep=0x0F with tlast; then poDone=1 and poFramesSent=1.
- P=50 → 8 beats, last tkeep=0xFF. P=10 → clamped to 46. P=1600 → clamped to 1500, giving 190 beats with last tkeep=0x03.
- Random tready back-pressure over 100 frames, piFrameCnt=100 → no tdata change while stalled; payload bytes match (seq+i) mod 256; poFramesSent=100.
- GAP_BEATS=2, continuous mode → exactly 2 cycles of tvalid=0 between each tlast and the next HDR0.
- Deassert piGenEn at beat 3 of a 1500-byte frame → the frame completes with tlast, then IDLE, and poBusy=0.
- Assert piReset_n low mid-frame → tvalid and tlast are 0 in the same cycle. After release with piGenEn=1, a new frame starts at HDR0 with seq=0.
